pad_mux_cfg_ctrl: RTL
=====================

Name: pad_mux_cfg_ctrl

Overview:
Configuration sequencer for the per-pad alp_mux_top array. It owns the func_sel, test_sel and func_test_sel vectors that drive the pad muxes. Each select change runs a glitch-safe sequence on the pads it touches: quiesce the pads, update the selects, settle, then release. It sits between the chip register block (simple valid/ready write port) and the pad mux top level.

Parameters:
N_PADS, 10, number of pads/mux instances controlled
FUNC_SEL_W, 2, func_sel bits per pad
TEST_SEL_W, 4, test_sel bits per pad
FUNC_WIDTH, 4, legal func_sel values 0..FUNC_WIDTH-1
TEST_WIDTH, 15, legal test_sel values 0..TEST_WIDTH-1
QUIESCE_CYC, 2, cycles pad_quiet is held before the select update; must be >=1
SETTLE_CYC, 2, cycles pad_quiet is held after the select update; must be >=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_valid  in  1  write request
wr_ready  out  1  controller can accept a request
wr_all  in  1  apply the request to all pads; wr_idx ignored
wr_idx  in  $clog2(N_PADS)  target pad index
wr_func_sel  in  FUNC_SEL_W  new functional select
wr_test_sel  in  TEST_SEL_W  new test select
wr_mode  in  1  new func_test_sel (0 = functional, 1 = test)
done  out  1  one-cycle pulse when an accepted request completes
err  out  1  one-cycle pulse when a request is rejected
busy  out  1  sequence in progress
func_sel  out  N_PADS*FUNC_SEL_W  pad i uses slice [i*FUNC_SEL_W +: FUNC_SEL_W]
test_sel  out  N_PADS*TEST_SEL_W  pad i uses slice [i*TEST_SEL_W +: TEST_SEL_W]
func_test_sel  out  N_PADS  per-pad functional/test mode
pad_quiet  out  N_PADS  per-pad force: pad OE/IE are driven low while the bit is 1
rd_idx  in  $clog2(N_PADS)  readback index
rd_func_sel / rd_test_sel / rd_mode  out  FUNC_SEL_W / TEST_SEL_W / 1  combinational readback of pad rd_idx

Behaviour:
- Reset values (asynchronous): func_sel=0, test_sel=0, func_test_sel=0, pad_quiet=0, busy=0, done=0, err=0, state=IDLE, wr_ready=1.
- States: IDLE, QUIESCE, UPDATE, SETTLE, DONE.
- wr_ready = (state==IDLE) || (state==DONE). A request is accepted in cycle 0 when wr_valid && wr_ready; the request fields are captured in cycle 0.
- Reject rule: reject if (!wr_all && wr_idx>=N_PADS), or wr_func_sel>=FUNC_WIDTH, or wr_test_sel>=TEST_WIDTH.
  - Response: err=1 in cycle 1, no state or output change, wr_ready stays 1.
- No-change rule: if every target pad already holds exactly the requested triple, done=1 in cycle 1. The sequence is skipped and pad_quiet never asserts.
- Normal sequence, with Q=QUIESCE_CYC and S=SETTLE_CYC:
  - Cycles 1..Q: QUIESCE. pad_quiet=1 for the target pad(s) (all pads if wr_all); busy=1.
  - Cycle Q+1: UPDATE. The select registers load and the new values are visible from cycle Q+2.
  - Cycles Q+2..Q+S+1: SETTLE. pad_quiet is still 1.
  - Cycle Q+S+2: DONE. pad_quiet=0, busy=0, done=1, wr_ready=1. An accept in DONE starts the next sequence with no idle gap.
  - Defaults Q=2, S=2: done in cycle 6.
- Select outputs never change while pad_quiet of the same pad is 0.
- A single timer implements the waits: a down counter loaded with Q-1 on entry to QUIESCE and with S-1 on entry to SETTLE. The state advances when the counter is 0.
- Readback is combinational. If rd_idx>=N_PADS, the readback outputs are 0.
- rst asserted mid-sequence:
  - All outputs return to reset values immediately.
  - pad_quiet drops, so pads revert to func_sel 0 in functional mode.
  - The in-flight request is lost and no done pulse is issued.
- done and err are never asserted in the same cycle.

Decomposition:
- pad_mux_cfg_pkg holds:
  - state enum;
  - defaults for FUNC_SEL_W, TEST_SEL_W, FUNC_WIDTH, TEST_WIDTH;
  - helper function for slice offset of pad i.
- Sub-module pad_mux_seq_timer: loadable down counter, width $clog2(max(Q,S)+1), with load, value and zero flag.

Test Plan:
- Reset, then write idx=3 func=1 test=0 mode=0:
  - pad_quiet[3]=1 in cycles 1-5 and 0 on every other bit;
  - func_sel[7:6]=1 from cycle 4;
  - done in cycle 6; readback idx 3 returns 1/0/0.
- Write idx=10 (invalid): err in cycle 1; all outputs unchanged.
- Write with test_sel=15 (invalid): err in cycle 1; no change.
- Repeat the same write as the previous test: done in cycle 1; pad_quiet stays 0 throughout.
- Write wr_all=1 mode=1 test=5:
  - pad_quiet=all-ones in cycles 1-5;
  - func_test_sel=all-ones and every test_sel slice=5 from cycle 4.
- Back-to-back writes with wr_valid held:
  - second request accepted in the DONE cycle of the first;
  - second done 6 cycles later.
- Assert rst at cycle 2 of a sequence: pad_quiet, busy and all selects are 0 in the same cycle; no done pulse.

Source files
------------

// File: rtl/pad_mux_cfg_pkg.sv
// Shared types and defaults for the pad mux configuration sequencer.
// Holds the sequencer state encoding and the per-pad slice helper.
package pad_mux_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUIESCE,
    UPDATE,
    SETTLE,
    DONE
  } state_t;

  localparam int DEF_FUNC_SEL_W = 2;
  localparam int DEF_TEST_SEL_W = 4;
  localparam int DEF_FUNC_WIDTH = 4;
  localparam int DEF_TEST_WIDTH = 15;

  function automatic int pad_off(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pad_mux_seq_timer.sv
// Loadable down counter used for the quiesce and settle waits.
// Holds at zero; load takes priority over decrement.
module pad_mux_seq_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/pad_mux_cfg_ctrl.sv
// Glitch-safe sequencer for the per-pad func/test selects: quiesce, update, settle, release.
// Accepts one write at a time (wr_ready in IDLE/DONE); rejects and no-op writes finish in one cycle.
module pad_mux_cfg_ctrl
  import pad_mux_cfg_pkg::*;
#(
  parameter int N_PADS      = 10,
  parameter int FUNC_SEL_W  = DEF_FUNC_SEL_W,
  parameter int TEST_SEL_W  = DEF_TEST_SEL_W,
  parameter int FUNC_WIDTH  = DEF_FUNC_WIDTH,
  parameter int TEST_WIDTH  = DEF_TEST_WIDTH,
  parameter int QUIESCE_CYC = 2,
  parameter int SETTLE_CYC  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic                           wr_all,
  input  logic [$clog2(N_PADS)-1:0]      wr_idx,
  input  logic [FUNC_SEL_W-1:0]          wr_func_sel,
  input  logic [TEST_SEL_W-1:0]          wr_test_sel,
  input  logic                           wr_mode,
  output logic                           done,
  output logic                           err,
  output logic                           busy,
  output logic [N_PADS*FUNC_SEL_W-1:0]   func_sel,
  output logic [N_PADS*TEST_SEL_W-1:0]   test_sel,
  output logic [N_PADS-1:0]              func_test_sel,
  output logic [N_PADS-1:0]              pad_quiet,
  input  logic [$clog2(N_PADS)-1:0]      rd_idx,
  output logic [FUNC_SEL_W-1:0]          rd_func_sel,
  output logic [TEST_SEL_W-1:0]          rd_test_sel,
  output logic                           rd_mode
);

  localparam int IDX_W = $clog2(N_PADS);
  localparam int MAX_CYC = (QUIESCE_CYC > SETTLE_CYC) ? QUIESCE_CYC : SETTLE_CYC;
  localparam int TMR_W = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] Q_LD = TMR_W'(QUIESCE_CYC - 1);
  localparam logic [TMR_W-1:0] S_LD = TMR_W'(SETTLE_CYC - 1);

  state_t state, state_n;

  logic                  req_all;
  logic [IDX_W-1:0]      req_idx;
  logic [FUNC_SEL_W-1:0] req_func_sel;
  logic [TEST_SEL_W-1:0] req_test_sel;
  logic                  req_mode;

  logic              wr_bad, wr_same, wr_acc;
  logic [N_PADS-1:0] tgt;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_load_val, tmr_value;

  pad_mux_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  assign wr_ready = (state == IDLE) || (state == DONE);
  assign wr_acc   = wr_valid && wr_ready;
  assign busy     = (state == QUIESCE) || (state == UPDATE) || (state == SETTLE);
  assign done     = (state == DONE);
  assign pad_quiet = busy ? tgt : '0;

  assign wr_bad = (!wr_all && (32'(wr_idx) >= N_PADS)) ||
                  (32'(wr_func_sel) >= FUNC_WIDTH) ||
                  (32'(wr_test_sel) >= TEST_WIDTH);

  // A write is a no-op only if every pad it targets already holds the full triple.
  always_comb begin
    wr_same = 1'b1;
    for (int i = 0; i < N_PADS; i++) begin
      if (wr_all || (32'(wr_idx) == i)) begin
        if ((func_sel[pad_off(i, FUNC_SEL_W) +: FUNC_SEL_W] != wr_func_sel) ||
            (test_sel[pad_off(i, TEST_SEL_W) +: TEST_SEL_W] != wr_test_sel) ||
            (func_test_sel[i] != wr_mode)) begin
          wr_same = 1'b0;
        end
      end
    end
  end

  always_comb begin
    tgt = '0;
    for (int i = 0; i < N_PADS; i++) begin
      tgt[i] = req_all || (32'(req_idx) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (wr_valid && !wr_bad) begin
          if (wr_same) begin
            state_n = DONE;
          end else begin
            state_n      = QUIESCE;
            tmr_load     = 1'b1;
            tmr_load_val = Q_LD;
          end
        end
      end
      QUIESCE: begin
        if (tmr_zero) state_n = UPDATE;
        else          tmr_dec = 1'b1;
      end
      UPDATE: begin
        state_n      = SETTLE;
        tmr_load     = 1'b1;
        tmr_load_val = S_LD;
      end
      SETTLE: begin
        if (tmr_zero) state_n = DONE;
        else          tmr_dec = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_all      <= 1'b0;
      req_idx      <= '0;
      req_func_sel <= '0;
      req_test_sel <= '0;
      req_mode     <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= wr_acc && wr_bad;
      if (wr_acc && !wr_bad) begin
        req_all      <= wr_all;
        req_idx      <= wr_idx;
        req_func_sel <= wr_func_sel;
        req_test_sel <= wr_test_sel;
        req_mode     <= wr_mode;
      end
    end
  end

  // Selects only move in UPDATE, where every targeted pad is already quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_sel      <= '0;
      test_sel      <= '0;
      func_test_sel <= '0;
    end else if (state == UPDATE) begin
      for (int i = 0; i < N_PADS; i++) begin
        if (tgt[i]) begin
          func_sel[pad_off(i, FUNC_SEL_W) +: FUNC_SEL_W] <= req_func_sel;
          test_sel[pad_off(i, TEST_SEL_W) +: TEST_SEL_W] <= req_test_sel;
          func_test_sel[i]                               <= req_mode;
        end
      end
    end
  end

  always_comb begin
    rd_func_sel = '0;
    rd_test_sel = '0;
    rd_mode     = 1'b0;
    for (int i = 0; i < N_PADS; i++) begin
      if (32'(rd_idx) == i) begin
        rd_func_sel = func_sel[pad_off(i, FUNC_SEL_W) +: FUNC_SEL_W];
        rd_test_sel = test_sel[pad_off(i, TEST_SEL_W) +: TEST_SEL_W];
        rd_mode     = func_test_sel[i];
      end
    end
  end

endmodule
